// File: rtl/board_state.sv
// Board register file: holds the 64-square position and applies moves through a
// valid/ready handshake. It also tracks side-to-move, ply count and material balance.
module board_state #(
  parameter int unsigned PLY_W = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    new_game,
  input  logic                    move_valid,
  output logic                    move_ready,
  input  logic [5:0]              move_from,
  input  logic [5:0]              move_to,
  input  logic [2:0]              move_promo,
  output logic                    move_done,
  output logic                    move_err,
  output logic [255:0]            board_flat,
  output logic                    white_to_move,
  output logic signed [15:0]      material,
  output logic [PLY_W-1:0]        ply_count
);

  localparam int unsigned NSQ     = 64;
  localparam int unsigned PIECE_W = 4;

  typedef enum logic [1:0] {IDLE, CHECK, COMMIT, REJECT} state_e;

  state_e                 state_q, state_d;
  logic [PIECE_W-1:0]     board_q [NSQ];
  logic [PIECE_W-1:0]     board_d [NSQ];
  logic                   wtm_q, wtm_d;
  logic signed [15:0]     mat_q, mat_d;
  logic [PLY_W-1:0]       ply_q, ply_d;
  logic [5:0]             from_q, from_d, to_q, to_d;
  logic [2:0]             promo_q, promo_d;

  logic [PIECE_W-1:0]     p_piece, q_piece;
  logic [2:0]             promo_type;
  logic                   is_promo, reject;
  logic signed [15:0]     delta;

  function automatic logic [2:0] back_type(input logic [2:0] file);
    case (file)
      3'd0, 3'd7: back_type = 3'd4;
      3'd1, 3'd6: back_type = 3'd2;
      3'd2, 3'd5: back_type = 3'd3;
      3'd3:       back_type = 3'd5;
      default:    back_type = 3'd6;
    endcase
  endfunction

  function automatic logic [PIECE_W-1:0] start_piece(input logic [5:0] sq);
    case (sq[5:3])
      3'd0:    start_piece = {1'b0, back_type(sq[2:0])};
      3'd1:    start_piece = 4'b0001;
      3'd6:    start_piece = 4'b1001;
      3'd7:    start_piece = {1'b1, back_type(sq[2:0])};
      default: start_piece = 4'b0000;
    endcase
  endfunction

  function automatic logic signed [15:0] piece_value(input logic [2:0] t);
    case (t)
      3'd1:    piece_value = 16'sd1;
      3'd2:    piece_value = 16'sd3;
      3'd3:    piece_value = 16'sd3;
      3'd4:    piece_value = 16'sd5;
      3'd5:    piece_value = 16'sd10;
      default: piece_value = 16'sd0;
    endcase
  endfunction

  // Move evaluation from the latched squares
  assign p_piece    = board_q[from_q];
  assign q_piece    = board_q[to_q];
  assign promo_type = (promo_q inside {[3'd2:3'd5]}) ? promo_q : 3'd5;
  assign is_promo   = (p_piece[2:0] == 3'd1) &&
                      ((!p_piece[3] && to_q[5:3] == 3'd7) || (p_piece[3] && to_q[5:3] == 3'd0));
  assign reject     = (p_piece[2:0] == 3'd0) || (p_piece[3] != !wtm_q) || (from_q == to_q) ||
                      ((q_piece[2:0] != 3'd0) && (q_piece[3] == p_piece[3])) ||
                      (q_piece[2:0] == 3'd6);
  assign delta      = is_promo ? (piece_value(q_piece[2:0]) + piece_value(promo_type) - 16'sd1)
                               : piece_value(q_piece[2:0]);

  always_comb begin
    state_d = state_q;
    board_d = board_q;
    wtm_d   = wtm_q;
    mat_d   = mat_q;
    ply_d   = ply_q;
    from_d  = from_q;
    to_d    = to_q;
    promo_d = promo_q;
    case (state_q)
      IDLE: begin
        if (new_game) begin
          for (int i = 0; i < NSQ; i++) board_d[i] = start_piece(6'(i));
          wtm_d = 1'b1;
          mat_d = 16'sd0;
          ply_d = '0;
        end else if (move_valid) begin
          from_d  = move_from;
          to_d    = move_to;
          promo_d = move_promo;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (reject) begin
          state_d = REJECT;
        end else begin
          state_d         = COMMIT;
          board_d[from_q] = 4'b0000;
          board_d[to_q]   = is_promo ? {p_piece[3], promo_type} : p_piece;
          mat_d           = p_piece[3] ? (mat_q - delta) : (mat_q + delta);
          wtm_d           = !wtm_q;
          if (ply_q != '1) ply_d = ply_q + PLY_W'(1);
        end
      end
      COMMIT:  state_d = IDLE;
      REJECT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      for (int i = 0; i < NSQ; i++) board_q[i] <= start_piece(6'(i));
      wtm_q   <= 1'b1;
      mat_q   <= 16'sd0;
      ply_q   <= '0;
      from_q  <= '0;
      to_q    <= '0;
      promo_q <= '0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      wtm_q   <= wtm_d;
      mat_q   <= mat_d;
      ply_q   <= ply_d;
      from_q  <= from_d;
      to_q    <= to_d;
      promo_q <= promo_d;
    end
  end

  for (genvar g = 0; g < NSQ; g++) begin : g_flat
    assign board_flat[PIECE_W*g +: PIECE_W] = board_q[g];
  end

  assign move_ready    = (state_q == IDLE) && !new_game;
  assign move_done     = (state_q == COMMIT);
  assign move_err      = (state_q == REJECT);
  assign white_to_move = wtm_q;
  assign material      = mat_q;
  assign ply_count     = ply_q;

endmodule

// File: tb/tb_board_state.sv
// Directed testbench for board_state: reset image, commits, rejects, captures,
// promotion, new_game, async reset abort and ply saturation.
module tb_board_state;
  localparam int unsigned PLY_W = 10;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               new_game = 1'b0;
  logic               move_valid = 1'b0;
  logic               move_ready;
  logic [5:0]         move_from = '0;
  logic [5:0]         move_to = '0;
  logic [2:0]         move_promo = '0;
  logic               move_done;
  logic               move_err;
  logic [255:0]       board_flat;
  logic               white_to_move;
  logic signed [15:0] material;
  logic [PLY_W-1:0]   ply_count;

  int checks = 0;
  int failures = 0;
  logic [255:0] start_img;
  bit d, e, r;

  board_state #(.PLY_W(PLY_W)) dut (
    .clk(clk), .rst(rst), .new_game(new_game), .move_valid(move_valid),
    .move_ready(move_ready), .move_from(move_from), .move_to(move_to),
    .move_promo(move_promo), .move_done(move_done), .move_err(move_err),
    .board_flat(board_flat), .white_to_move(white_to_move),
    .material(material), .ply_count(ply_count)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] sqv(input int n);
    return board_flat[4*n +: 4];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; new_game = 1'b0; move_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  // Drives one move; returns done/err at T+2 and ready at T+3. Inputs are scrambled after accept.
  task automatic do_move(input logic [5:0] f, input logic [5:0] t, input logic [2:0] pr,
                         output bit dn, output bit er, output bit rd);
    move_from = f; move_to = t; move_promo = pr; move_valid = 1'b1;
    tick();
    move_valid = 1'b0; move_from = 6'd63; move_to = 6'd62; move_promo = 3'd2;
    tick();
    dn = move_done; er = move_err;
    tick();
    rd = move_ready;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (board_flat !== start_img) begin failures++; $display("FAIL reset_board: got %h exp %h", board_flat, start_img); end
    checks++; if (sqv(4) !== 4'b0110 || sqv(60) !== 4'b1110 || sqv(12) !== 4'b0001) begin failures++; $display("FAIL reset_squares: got sq4=%b sq60=%b sq12=%b exp 0110 1110 0001", sqv(4), sqv(60), sqv(12)); end
    checks++; if (material !== 16'sd0 || white_to_move !== 1'b1 || ply_count !== '0) begin failures++; $display("FAIL reset_regs: got mat=%0d wtm=%b ply=%0d exp 0 1 0", material, white_to_move, ply_count); end
    checks++; if (move_ready !== 1'b1 || move_done !== 1'b0 || move_err !== 1'b0) begin failures++; $display("FAIL reset_hs: got rdy=%b done=%b err=%b exp 1 0 0", move_ready, move_done, move_err); end
  endtask

  task automatic test_commit();
    apply_reset();
    do_move(6'd12, 6'd28, 3'd0, d, e, r);
    checks++; if (d !== 1'b1 || e !== 1'b0) begin failures++; $display("FAIL e4_pulse: got done=%b err=%b exp 1 0", d, e); end
    checks++; if (r !== 1'b1) begin failures++; $display("FAIL e4_ready_t3: got %b exp 1", r); end
    checks++; if (sqv(28) !== 4'b0001 || sqv(12) !== 4'b0000) begin failures++; $display("FAIL e4_board: got sq28=%b sq12=%b exp 0001 0000", sqv(28), sqv(12)); end
    checks++; if (white_to_move !== 1'b0 || ply_count !== 10'd1 || material !== 16'sd0) begin failures++; $display("FAIL e4_regs: got wtm=%b ply=%0d mat=%0d exp 0 1 0", white_to_move, ply_count, material); end
  endtask

  task automatic test_reject();
    logic [5:0] rf [4] = '{6'd52, 6'd12, 6'd0, 6'd12};
    logic [5:0] rt [4] = '{6'd36, 6'd12, 6'd1, 6'd60};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      do_move(rf[i], rt[i], 3'd0, d, e, r);
      checks++; if (e !== 1'b1 || d !== 1'b0) begin failures++; $display("FAIL reject_%0d_pulse: got err=%b done=%b exp 1 0", i, e, d); end
      checks++; if (board_flat !== start_img || material !== 16'sd0 || ply_count !== '0 || white_to_move !== 1'b1) begin failures++; $display("FAIL reject_%0d_state: got mat=%0d ply=%0d wtm=%b board_changed=%b exp 0 0 1 0", i, material, ply_count, white_to_move, board_flat !== start_img); end
    end
  endtask

  task automatic test_capture();
    apply_reset();
    do_move(6'd12, 6'd28, 3'd0, d, e, r);
    do_move(6'd51, 6'd35, 3'd0, d, e, r);
    do_move(6'd28, 6'd35, 3'd0, d, e, r);
    checks++; if (material !== 16'sd1 || sqv(35) !== 4'b0001 || sqv(28) !== 4'b0000) begin failures++; $display("FAIL exd5: got mat=%0d sq35=%b sq28=%b exp 1 0001 0000", material, sqv(35), sqv(28)); end
    checks++; if (ply_count !== 10'd3 || white_to_move !== 1'b0) begin failures++; $display("FAIL exd5_regs: got ply=%0d wtm=%b exp 3 0", ply_count, white_to_move); end
    do_move(6'd59, 6'd35, 3'd0, d, e, r);
    checks++; if (d !== 1'b1 || material !== 16'sd0 || sqv(35) !== 4'b1101 || ply_count !== 10'd4) begin failures++; $display("FAIL qxd5: got done=%b mat=%0d sq35=%b ply=%0d exp 1 0 1101 4", d, material, sqv(35), ply_count); end
  endtask

  task automatic test_promo();
    logic [2:0]  pr [3]   = '{3'd5, 3'd7, 3'd3};
    logic [3:0]  pc [3]   = '{4'b0101, 4'b0101, 4'b0011};
    logic [15:0] pm [3]   = '{16'd13, 16'd13, 16'd6};
    for (int i = 0; i < 3; i++) begin
      apply_reset();
      do_move(6'd8, 6'd48, 3'd0, d, e, r);
      do_move(6'd55, 6'd47, 3'd0, d, e, r);
      do_move(6'd48, 6'd57, pr[i], d, e, r);
      checks++; if (d !== 1'b1 || sqv(57) !== pc[i] || sqv(48) !== 4'b0000) begin failures++; $display("FAIL promo_%0d_board: got done=%b sq57=%b sq48=%b exp 1 %b 0000", i, d, sqv(57), sqv(48), pc[i]); end
      checks++; if (material !== $signed(pm[i])) begin failures++; $display("FAIL promo_%0d_mat: got %0d exp %0d", i, material, $signed(pm[i])); end
    end
  endtask

  task automatic test_new_game();
    apply_reset();
    do_move(6'd12, 6'd28, 3'd0, d, e, r);
    do_move(6'd51, 6'd35, 3'd0, d, e, r);
    do_move(6'd28, 6'd35, 3'd0, d, e, r);
    new_game = 1'b1; move_valid = 1'b1; move_from = 6'd12; move_to = 6'd20;
    #1;
    checks++; if (move_ready !== 1'b0) begin failures++; $display("FAIL ng_ready: got %b exp 0", move_ready); end
    tick();
    new_game = 1'b0; move_valid = 1'b0;
    checks++; if (board_flat !== start_img || material !== 16'sd0 || ply_count !== '0 || white_to_move !== 1'b1) begin failures++; $display("FAIL ng_state: got mat=%0d ply=%0d wtm=%b board_changed=%b exp 0 0 1 0", material, ply_count, white_to_move, board_flat !== start_img); end
    tick(); tick();
    checks++; if (move_done !== 1'b0 || move_err !== 1'b0 || board_flat !== start_img) begin failures++; $display("FAIL ng_no_move: got done=%b err=%b board_changed=%b exp 0 0 0", move_done, move_err, board_flat !== start_img); end
  endtask

  task automatic test_rst_abort();
    bit seen;
    apply_reset();
    do_move(6'd12, 6'd28, 3'd0, d, e, r);
    do_move(6'd52, 6'd36, 3'd0, d, e, r);
    move_from = 6'd11; move_to = 6'd27; move_valid = 1'b1;
    tick();
    move_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (board_flat !== start_img || ply_count !== '0 || white_to_move !== 1'b1) begin failures++; $display("FAIL rst_async: got ply=%0d wtm=%b board_changed=%b exp 0 1 0", ply_count, white_to_move, board_flat !== start_img); end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (move_done === 1'b1 || move_err === 1'b1) seen = 1'b1;
      tick();
      if (i == 1) rst = 1'b0;
    end
    checks++; if (seen !== 1'b0 || move_done !== 1'b0 || board_flat !== start_img) begin failures++; $display("FAIL rst_abort: got pulse_seen=%b done=%b board_changed=%b exp 0 0 0", seen, move_done, board_flat !== start_img); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] mf [4] = '{6'd6, 6'd62, 6'd21, 6'd45};
    logic [5:0] mt [4] = '{6'd21, 6'd45, 6'd6, 6'd62};
    int bad;
    apply_reset();
    bad = 0;
    for (int k = 0; k < 1024; k++) begin
      do_move(mf[k % 4], mt[k % 4], 3'd0, d, e, r);
      if (d !== 1'b1 || e !== 1'b0 || r !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL b2b_moves: got %0d bad moves exp 0", bad); end
    checks++; if (ply_count !== 10'd1023 || white_to_move !== 1'b1 || board_flat !== start_img) begin failures++; $display("FAIL ply_sat: got ply=%0d wtm=%b board_changed=%b exp 1023 1 0", ply_count, white_to_move, board_flat !== start_img); end
  endtask

  initial begin
    start_img = {32'hCABEDBAC, 32'h99999999, 128'h0, 32'h11111111, 32'h42365324};
    test_reset();
    test_commit();
    test_reject();
    test_capture();
    test_promo();
    test_new_game();
    test_rst_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
